// File: rtl/pc_gen_pkg.sv
// Shared types and default vectors for the fetch-stage program-counter generator.
package pc_gen_pkg;

  localparam int          DEF_XLEN       = 32;
  localparam logic [31:0] DEF_RESET_VEC  = 32'h0000_0000;
  localparam logic [31:0] DEF_TRAP_VEC   = 32'h0000_0100;
  localparam int          DEF_STEP       = 4;
  localparam int          DEF_ALIGN_BITS = 2;

  // Encoding 3 is unused and recovers to BOOT.
  typedef enum logic [1:0] {
    BOOT = 2'd0,
    RUN  = 2'd1,
    HALT = 2'd2
  } pc_state_e;

  // Which source wins the pc update in a given cycle.
  typedef enum logic [2:0] {
    NONE     = 3'd0,
    SEQ      = 3'd1,
    BRANCH   = 3'd2,
    TRAP     = 3'd3,
    MISALIGN = 3'd4
  } pc_cause_e;

endpackage

// File: rtl/pc_gen_if.sv
// Redirect requests and fetch handshake between resolution logic, the PC
// generator and the instruction-fetch stage.
interface pc_gen_if
  import pc_gen_pkg::*;
#(
  parameter int XLEN = DEF_XLEN
) ();

  logic            stall;
  logic            br_taken;
  logic [XLEN-1:0] br_target;
  logic            trap;
  logic            halt_req;
  logic            resume;
  logic            if_ready;
  logic [XLEN-1:0] pc;
  logic            pc_valid;
  logic [XLEN-1:0] pc_next;
  logic            misalign;
  pc_state_e       state;

  // Requester / fetch side.
  modport master (
    output stall, br_taken, br_target, trap, halt_req, resume, if_ready,
    input  pc, pc_valid, pc_next, misalign, state
  );

  // PC generator side.
  modport slave (
    input  stall, br_taken, br_target, trap, halt_req, resume, if_ready,
    output pc, pc_valid, pc_next, misalign, state
  );

endinterface

// File: rtl/pc_next_sel.sv
// Combinational priority mux choosing the next fetch address.
// pc_next is exactly the value the pc register captures at the next edge.
module pc_next_sel
  import pc_gen_pkg::*;
#(
  parameter int              XLEN       = DEF_XLEN,
  parameter logic [XLEN-1:0] RESET_VEC  = XLEN'(DEF_RESET_VEC),
  parameter logic [XLEN-1:0] TRAP_VEC   = XLEN'(DEF_TRAP_VEC),
  parameter int              STEP       = DEF_STEP,
  parameter int              ALIGN_BITS = DEF_ALIGN_BITS
) (
  input  logic [XLEN-1:0] pc,
  input  pc_state_e       state,
  input  logic            pc_valid,
  input  logic            stall,
  input  logic            br_taken,
  input  logic [XLEN-1:0] br_target,
  input  logic            trap,
  input  logic            halt_req,
  input  logic            if_ready,
  output logic [XLEN-1:0] pc_next,
  output logic            pc_load,
  output logic            mis_det
);

  // ALIGN_BITS of zero gives an empty mask, which disables the check.
  localparam logic [XLEN-1:0] ALIGN_MASK = (XLEN'(1) << ALIGN_BITS) - XLEN'(1);

  // Sequential advance wraps modulo 2^XLEN with no carry out.
  function automatic logic [XLEN-1:0] seq_addr(input logic [XLEN-1:0] a);
    return a + XLEN'(STEP);
  endfunction

  function automatic logic target_misaligned(input logic [XLEN-1:0] t);
    return |(t & ALIGN_MASK);
  endfunction

  pc_cause_e cause;

  // Pick the winning update source, then map it to an address.
  // A halting edge does not advance: the fetch at the current pc is
  // presented again after resume.
  always_comb begin
    cause   = NONE;
    pc_next = pc;
    pc_load = 1'b0;
    mis_det = 1'b0;
    if (state == BOOT) begin
      pc_next = RESET_VEC;
      pc_load = 1'b1;
    end else if (state == RUN || state == HALT) begin
      if (trap)
        cause = TRAP;
      else if (br_taken && target_misaligned(br_target))
        cause = MISALIGN;
      else if (br_taken)
        cause = BRANCH;
      else if (state == RUN && pc_valid && if_ready && !stall && !halt_req)
        cause = SEQ;

      case (cause)
        TRAP, MISALIGN: pc_next = TRAP_VEC;
        BRANCH:         pc_next = br_target;
        SEQ:            pc_next = seq_addr(pc);
        default:        pc_next = pc;
      endcase
      pc_load = (cause != NONE);
      mis_det = (cause == MISALIGN);
    end
  end

endmodule

// File: rtl/pc_gen_unit.sv
// RV32 fetch-stage program-counter generator: holds pc, fetch-valid,
// misalign pulse and the BOOT/RUN/HALT control state.
module pc_gen_unit
  import pc_gen_pkg::*;
#(
  parameter int              XLEN       = DEF_XLEN,
  parameter logic [XLEN-1:0] RESET_VEC  = XLEN'(DEF_RESET_VEC),
  parameter logic [XLEN-1:0] TRAP_VEC   = XLEN'(DEF_TRAP_VEC),
  parameter int              STEP       = DEF_STEP,
  parameter int              ALIGN_BITS = DEF_ALIGN_BITS
) (
  input  logic    clk,
  input  logic    rst,
  pc_gen_if.slave bus
);

  pc_state_e       state_q;
  pc_state_e       state_d;
  logic            pc_valid_q;
  logic            pc_valid_d;
  logic [XLEN-1:0] pc_q;
  logic [XLEN-1:0] pc_next;
  logic            pc_load;
  logic            mis_det;
  logic            misalign_q;

  pc_next_sel #(
    .XLEN       (XLEN),
    .RESET_VEC  (RESET_VEC),
    .TRAP_VEC   (TRAP_VEC),
    .STEP       (STEP),
    .ALIGN_BITS (ALIGN_BITS)
  ) u_sel (
    .pc        (pc_q),
    .state     (state_q),
    .pc_valid  (pc_valid_q),
    .stall     (bus.stall),
    .br_taken  (bus.br_taken),
    .br_target (bus.br_target),
    .trap      (bus.trap),
    .halt_req  (bus.halt_req),
    .if_ready  (bus.if_ready),
    .pc_next   (pc_next),
    .pc_load   (pc_load),
    .mis_det   (mis_det)
  );

  // Next control state; trap beats halt_req in RUN, trap or resume wake HALT.
  always_comb begin
    state_d    = state_q;
    pc_valid_d = 1'b0;
    case (state_q)
      BOOT: begin
        state_d    = RUN;
        pc_valid_d = 1'b1;
      end
      RUN: begin
        if (bus.halt_req && !bus.trap)
          state_d = HALT;
        else
          pc_valid_d = 1'b1;
      end
      HALT: begin
        if (bus.trap || bus.resume) begin
          state_d    = RUN;
          pc_valid_d = 1'b1;
        end
      end
      default: state_d = BOOT;
    endcase
  end

  // Register pc, control state, fetch-valid and the one-cycle misalign flag.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= BOOT;
      pc_valid_q <= 1'b0;
      pc_q       <= RESET_VEC;
      misalign_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_valid_q <= pc_valid_d;
      misalign_q <= mis_det;
      if (pc_load)
        pc_q <= pc_next;
    end
  end

  assign bus.pc       = pc_q;
  assign bus.pc_valid = pc_valid_q;
  assign bus.pc_next  = pc_next;
  assign bus.misalign = misalign_q;
  assign bus.state    = state_q;

endmodule

// File: tb/tb_pc_gen_unit.sv
// Directed bench for pc_gen_unit: a 32-bit instance with the default reset
// vector and a 64-bit instance with RESET_VEC=0x8000_0000 run the same
// control stimulus side by side.
module tb_pc_gen_unit;
  import pc_gen_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        stall = 1'b0;
  logic        br_taken = 1'b0;
  logic        trap = 1'b0;
  logic        halt_req = 1'b0;
  logic        resume = 1'b0;
  logic        if_ready = 1'b1;
  logic [31:0] tgt32 = '0;
  logic [63:0] tgt64 = '0;

  int nvec = 0;
  int nmis = 0;

  localparam logic [63:0] RV64 = 64'h8000_0000;

  always #5 clk = ~clk;

  pc_gen_if #(.XLEN(32)) b32 ();
  pc_gen_if #(.XLEN(64)) b64 ();

  assign b32.stall     = stall;
  assign b32.br_taken  = br_taken;
  assign b32.br_target = tgt32;
  assign b32.trap      = trap;
  assign b32.halt_req  = halt_req;
  assign b32.resume    = resume;
  assign b32.if_ready  = if_ready;

  assign b64.stall     = stall;
  assign b64.br_taken  = br_taken;
  assign b64.br_target = tgt64;
  assign b64.trap      = trap;
  assign b64.halt_req  = halt_req;
  assign b64.resume    = resume;
  assign b64.if_ready  = if_ready;

  pc_gen_unit #(.XLEN(32)) dut32 (
    .clk (clk),
    .rst (rst),
    .bus (b32)
  );

  pc_gen_unit #(.XLEN(64), .RESET_VEC(64'h8000_0000)) dut64 (
    .clk (clk),
    .rst (rst),
    .bus (b64)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    nvec++;
    if (got !== exp) begin
      nmis++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic chk_pc(input string tag, input logic [63:0] e32, input logic [63:0] e64);
    chk({tag, " pc32"}, 64'(b32.pc), e32);
    chk({tag, " pc64"}, b64.pc, e64);
  endtask

  task automatic chk_ctl(input string tag, input logic [1:0] st, input logic vld, input logic mis);
    chk({tag, " state32"}, 64'(b32.state), 64'(st));
    chk({tag, " state64"}, 64'(b64.state), 64'(st));
    chk({tag, " valid32"}, 64'(b32.pc_valid), 64'(vld));
    chk({tag, " valid64"}, 64'(b64.pc_valid), 64'(vld));
    chk({tag, " mis32"}, 64'(b32.misalign), 64'(mis));
    chk({tag, " mis64"}, 64'(b64.misalign), 64'(mis));
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic set_tgt(input logic [63:0] v);
    tgt32 = v[31:0];
    tgt64 = v;
  endtask

  initial begin
    // reset state
    @(posedge clk);
    #1;
    chk_pc("reset", 64'h0, RV64);
    chk_ctl("reset", 2'd0, 1'b0, 1'b0);
    chk("reset pc_next32", 64'(b32.pc_next), 64'h0);
    chk("reset pc_next64", b64.pc_next, RV64);

    // boot then sequential advance
    rst = 1'b1;
    step(1);
    chk_pc("boot", 64'h0, RV64);
    chk_ctl("boot", 2'd1, 1'b1, 1'b0);
    step(1);
    chk_pc("seq1", 64'h4, RV64 + 64'h4);
    chk("seq1 pc_next32", 64'(b32.pc_next), 64'h8);
    chk("seq1 pc_next64", b64.pc_next, RV64 + 64'h8);
    step(1);
    chk_pc("seq2", 64'h8, RV64 + 64'h8);
    step(2);
    chk_pc("seq4", 64'h10, RV64 + 64'h10);

    // stall holds, branch overrides stall
    stall = 1'b1;
    step(3);
    chk_pc("stall", 64'h10, RV64 + 64'h10);
    chk("stall pc_next32", 64'(b32.pc_next), 64'h10);
    br_taken = 1'b1;
    set_tgt(64'h40);
    step(1);
    chk_pc("br_stall", 64'h40, 64'h40);
    stall = 1'b0;

    // misaligned redirect, one-cycle pulse
    set_tgt(64'h42);
    step(1);
    chk_pc("misalign", 64'h100, 64'h100);
    chk_ctl("misalign", 2'd1, 1'b1, 1'b1);
    br_taken = 1'b0;
    step(1);
    chk_pc("after_mis", 64'h104, 64'h104);
    chk_ctl("after_mis", 2'd1, 1'b1, 1'b0);

    // trap beats aligned branch
    trap = 1'b1;
    br_taken = 1'b1;
    set_tgt(64'h40);
    step(1);
    chk_pc("trap_br", 64'h100, 64'h100);
    chk_ctl("trap_br", 2'd1, 1'b1, 1'b0);
    trap = 1'b0;
    set_tgt(64'h20);
    step(1);
    chk_pc("br20", 64'h20, 64'h20);
    br_taken = 1'b0;

    // halt holds pc despite if_ready, resume re-presents it
    halt_req = 1'b1;
    step(1);
    chk_pc("halt", 64'h20, 64'h20);
    chk_ctl("halt", 2'd2, 1'b0, 1'b0);
    halt_req = 1'b0;
    step(4);
    chk_pc("halt_hold", 64'h20, 64'h20);
    chk_ctl("halt_hold", 2'd2, 1'b0, 1'b0);
    resume = 1'b1;
    step(1);
    chk_pc("resume", 64'h20, 64'h20);
    chk_ctl("resume", 2'd1, 1'b1, 1'b0);
    resume = 1'b0;
    step(1);
    chk_pc("resume_seq", 64'h24, 64'h24);

    // branch inside HALT, trap wakes
    halt_req = 1'b1;
    step(1);
    chk_pc("halt2", 64'h24, 64'h24);
    halt_req = 1'b0;
    br_taken = 1'b1;
    set_tgt(64'h80);
    step(1);
    chk_pc("halt_br", 64'h80, 64'h80);
    chk_ctl("halt_br", 2'd2, 1'b0, 1'b0);
    br_taken = 1'b0;
    trap = 1'b1;
    step(1);
    chk_pc("halt_trap", 64'h100, 64'h100);
    chk_ctl("halt_trap", 2'd1, 1'b1, 1'b0);

    // trap with halt_req stays RUN
    halt_req = 1'b1;
    step(1);
    chk_ctl("trap_halt", 2'd1, 1'b1, 1'b0);
    trap = 1'b0;
    step(1);
    chk_pc("halt3", 64'h100, 64'h100);
    chk_ctl("halt3", 2'd2, 1'b0, 1'b0);

    // resume beats halt_req
    resume = 1'b1;
    step(1);
    chk_ctl("resume_halt", 2'd1, 1'b1, 1'b0);
    resume = 1'b0;
    halt_req = 1'b0;
    step(1);
    chk_pc("resume2_seq", 64'h104, 64'h104);

    // wrap at top of address space
    br_taken = 1'b1;
    tgt32 = 32'hFFFF_FFFC;
    tgt64 = 64'hFFFF_FFFF_FFFF_FFFC;
    step(1);
    chk_pc("top", 64'hFFFF_FFFC, 64'hFFFF_FFFF_FFFF_FFFC);
    br_taken = 1'b0;
    step(1);
    chk_pc("wrap", 64'h0, 64'h0);
    chk_ctl("wrap", 2'd1, 1'b1, 1'b0);
    step(1);
    chk_pc("wrap_seq", 64'h4, 64'h4);

    // asynchronous reset mid-stream, pending branch dropped
    br_taken = 1'b1;
    set_tgt(64'h40);
    rst = 1'b0;
    #2;
    chk_pc("async_rst", 64'h0, RV64);
    chk_ctl("async_rst", 2'd0, 1'b0, 1'b0);
    br_taken = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end

endmodule

// File: doc/pc_gen_unit.md
Name: pc_gen_unit

Overview:
Parametrised program-counter generator for the RV32 fetch stage. It is the successor to the fixed 32-bit PC register, which offered only stall and branch load.
- Adds a configurable reset vector and trap vector, a priority-ordered redirect path, and target alignment checking.
- Adds a halt/resume state machine and a valid/ready handshake toward instruction fetch.
- Sits between the branch/exception resolution logic and the instruction memory address port.

Parameters:
XLEN, 32, PC width in bits
RESET_VEC, 32'h0000_0000, first fetch address after reset (XLEN bits)
TRAP_VEC, 32'h0000_0100, address loaded on trap or misaligned redirect
STEP, 4, sequential increment in bytes
ALIGN_BITS, 2, low target bits that must be zero; 0 disables the check

Ports:
clk  in  1  system clock, rising edge
rst  in  1  asynchronous active-low reset
stall  in  1  hazard stall; blocks sequential advance only
br_taken  in  1  branch/jump redirect request (one-cycle qualifier)
br_target  in  XLEN  redirect address
trap  in  1  exception/interrupt redirect to TRAP_VEC
halt_req  in  1  request to stop issuing fetches
resume  in  1  leave HALT
if_ready  in  1  fetch stage accepts current pc
pc  out  XLEN  current fetch address (registered)
pc_valid  out  1  pc is a live fetch request
pc_next  out  XLEN  combinational value pc takes at next edge
misalign  out  1  registered one-cycle pulse: rejected misaligned br_target
state  out  2  BOOT=0, RUN=1, HALT=2

Behaviour:
- Reset (rst=0, asynchronous): pc=RESET_VEC, pc_valid=0, misalign=0, state=BOOT.
- BOOT: the first edge after reset release moves to RUN with pc_valid=1 and pc=RESET_VEC unchanged. Inputs are ignored in BOOT.
- RUN update priority at each edge, highest first:
  1. trap: pc<=TRAP_VEC.
  2. br_taken with misaligned target (br_target[ALIGN_BITS-1:0]!=0): pc<=TRAP_VEC, misalign<=1.
  3. br_taken, aligned: pc<=br_target.
  4. pc_valid & if_ready & !stall: pc<=pc+STEP.
  5. Otherwise pc holds.
- Redirect interaction with stall/if_ready: redirects (items 1-3) override stall and if_ready; the un-accepted fetch is dropped.
- Arithmetic: pc+STEP is modulo 2^XLEN. For example, with XLEN=32, 32'hFFFF_FFFC + 4 -> 32'h0000_0000, with no flag.
- misalign: asserts for exactly one cycle per rejected redirect and is 0 otherwise.
- RUN -> HALT on halt_req when trap=0:
  - pc_valid<=0 at the same edge.
  - A redirect in the same cycle is still applied to pc.
  - trap together with halt_req: trap wins and state stays RUN.
- HALT:
  - pc_valid=0; sequential advance is disabled.
  - br_taken updates pc (with alignment check) and state stays HALT.
  - trap loads TRAP_VEC and moves to RUN (trap wakes the core).
  - resume moves to RUN with pc_valid=1 next cycle; resume has priority over a concurrent halt_req.
- Unused state encoding 3 returns to BOOT.
- pc_next: combinational and equal to the register's D input, so the I-cache can index one cycle early. In BOOT, pc_next=RESET_VEC.
- Reset asserted mid-operation: all outputs return to reset values immediately. Any pending redirect is lost.

Decomposition:
- Package pc_gen_pkg holds:
  - state encodings BOOT/RUN/HALT;
  - redirect cause constants NONE, SEQ, BRANCH, TRAP, MISALIGN;
  - default vector localparams.
- One sub-module, pc_next_sel: purely combinational priority mux. It takes pc, state and requests, and produces pc_next, the load-enable and the misalign detect.
- pc_gen_unit holds the pc/state/pc_valid/misalign registers.

Test Plan:
1. Reset release with STEP=4 and if_ready=1 held: pc sequence 0x0 (BOOT), 0x0 (first RUN cycle, pc_valid=1), 0x4, 0x8. state reads 0 -> 1.
2. stall=1 for 3 cycles at pc=0x10 -> pc holds 0x10. Then br_taken=1, br_target=0x40 while stall=1 -> pc=0x40 on the next edge.
3. br_taken with target 0x42 (ALIGN_BITS=2) -> pc=0x100, misalign=1 for one cycle then 0. trap and aligned br_taken in the same cycle -> pc=0x100, misalign=0.
4. halt_req at pc=0x20 -> state=2, pc_valid=0, pc holds 0x20 for 5 cycles despite if_ready=1. resume -> state=1, pc_valid=1, then 0x24.
5. In HALT, br_taken to 0x80 -> pc=0x80 with state still 2. Then trap -> pc=0x100, state=1.
6. pc=32'hFFFF_FFFC with advance -> 32'h0000_0000. Assert rst mid-stream -> pc=RESET_VEC, pc_valid=0 without waiting for a clock edge. Repeat with XLEN=64 and RESET_VEC=64'h8000_0000 -> identical sequencing.
